// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2: single-clock FIFO with valid/ready write, FWFT or registered read,
// programmable almost-full/almost-empty thresholds, occupancy, sticky ovf/udf.
// Optional high-water mark register enabled by defining SYNC_FIFO_PEAK_EN.
module sync_fifo_v2 #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int FWFT   = 0,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_dvalid,
    output logic              empty,
    output logic              full,
    output logic [CW-1:0]     count,
    input  logic [CW-1:0]     cfg_afull_th,
    input  logic [CW-1:0]     cfg_aempty_th,
    output logic              alm_full,
    output logic              alm_empty,
    input  logic              clr_err,
    output logic              ovf,
    output logic              udf,
    output logic [CW-1:0]     peak
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    assign empty     = count == '0;
    assign full      = count == CW'(DEPTH);
    assign wr_ready  = !full;
    assign wr_acc    = wr_valid & wr_ready;
    assign rd_acc    = rd_en & !empty;
    assign alm_full  = count >= cfg_afull_th;
    assign alm_empty = count <= cfg_aempty_th;

    // storage is deliberately left unreset; only pointers define validity
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= wr_data;
    end

    // pointers wrap at DEPTH-1 so non-power-of-two depths work; count tracks occupancy
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(wr_acc) - CW'(rd_acc);
        end
    end

    // sticky error flags; a new error in the same cycle as clr_err keeps the flag set
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= (wr_valid & !wr_ready) | (ovf & !clr_err);
            udf <= (rd_en & empty) | (udf & !clr_err);
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign rd_data   = mem[rd_ptr];
        assign rd_dvalid = !empty;
    end else begin : g_reg
        // registered read: data captured on pop, valid pulses for one cycle
        always_ff @(posedge clk) begin
            if (!rstn) begin
                rd_data   <= '0;
                rd_dvalid <= 1'b0;
            end else begin
                rd_dvalid <= rd_acc;
                if (rd_acc) rd_data <= mem[rd_ptr];
            end
        end
    end

`ifdef SYNC_FIFO_PEAK_EN
    // high-water mark follows count one cycle late; clr_err rebases it to current occupancy
    always_ff @(posedge clk) begin
        if (!rstn) peak <= '0;
        else if (clr_err) peak <= count;
        else if (count > peak) peak <= count;
    end
`else
    assign peak = '0;
`endif
endmodule

// File: tb/tb_sync_fifo_v2.sv
// tb_sync_fifo_v2: registered-read and FWFT instances driven in lockstep, checked against a queue model
module tb_sync_fifo_v2;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int CW     = 4;

    logic              clk;
    logic              rstn;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [CW-1:0]     cfg_afull_th;
    logic [CW-1:0]     cfg_aempty_th;
    logic              clr_err;

    logic              wr_ready_r, rd_dvalid_r, empty_r, full_r, alm_full_r, alm_empty_r, ovf_r, udf_r;
    logic [DATA_W-1:0] rd_data_r;
    logic [CW-1:0]     count_r, peak_r;
    logic              wr_ready_f, rd_dvalid_f, empty_f, full_f, alm_full_f, alm_empty_f, ovf_f, udf_f;
    logic [DATA_W-1:0] rd_data_f;
    logic [CW-1:0]     count_f, peak_f;

    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0] q[$];
    logic              m_ovf, m_udf, m_dv;
    logic [DATA_W-1:0] m_rdata;
    int                m_peak;

    sync_fifo_v2 #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(0)) dut_r (
        .clk(clk), .rstn(rstn), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready_r),
        .rd_en(rd_en), .rd_data(rd_data_r), .rd_dvalid(rd_dvalid_r), .empty(empty_r), .full(full_r),
        .count(count_r), .cfg_afull_th(cfg_afull_th), .cfg_aempty_th(cfg_aempty_th),
        .alm_full(alm_full_r), .alm_empty(alm_empty_r), .clr_err(clr_err), .ovf(ovf_r), .udf(udf_r),
        .peak(peak_r)
    );

    sync_fifo_v2 #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(1)) dut_f (
        .clk(clk), .rstn(rstn), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready_f),
        .rd_en(rd_en), .rd_data(rd_data_f), .rd_dvalid(rd_dvalid_f), .empty(empty_f), .full(full_f),
        .count(count_f), .cfg_afull_th(cfg_afull_th), .cfg_aempty_th(cfg_aempty_th),
        .alm_full(alm_full_f), .alm_empty(alm_empty_f), .clr_err(clr_err), .ovf(ovf_f), .udf(udf_f),
        .peak(peak_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // advance one clock, updating the reference model with the inputs presented this cycle
    task automatic tick();
        int n;
        n = q.size();
        if (!rstn) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_dv = 1'b0;
            m_rdata = '0;
            m_peak = 0;
        end else begin
            m_dv = rd_en && n > 0;
            if (m_dv) m_rdata = q[0];
            m_ovf = (wr_valid && n == DEPTH) || (m_ovf && !clr_err);
            m_udf = (rd_en && n == 0) || (m_udf && !clr_err);
`ifdef SYNC_FIFO_PEAK_EN
            if (clr_err) m_peak = n;
            else if (n > m_peak) m_peak = n;
`endif
            if (m_dv) void'(q.pop_front());
            if (wr_valid && n < DEPTH) q.push_back(wr_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        wr_valid = 1'b0;
        rd_en = 1'b0;
        clr_err = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        wr_valid = 1'b1;
        wr_data = 8'h5C;
        tick();
        do_reset();
        checks++;
        if (count_r !== 4'd0 || count_f !== 4'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d/%0d exp=0", count_r, count_f);
        end
        checks++;
        if ({empty_r, full_r, wr_ready_r} !== 3'b101) begin
            failures++;
            $display("FAIL reset_flags empty/full/wr_ready got=%b exp=101", {empty_r, full_r, wr_ready_r});
        end
        checks++;
        if ({rd_dvalid_r, rd_data_r, rd_dvalid_f} !== 10'd0) begin
            failures++;
            $display("FAIL reset_read got dv=%b data=%0h dvf=%b exp=0", rd_dvalid_r, rd_data_r, rd_dvalid_f);
        end
        checks++;
        if ({ovf_r, udf_r, peak_r} !== 6'd0) begin
            failures++;
            $display("FAIL reset_err got ovf=%b udf=%b peak=%0d exp=0", ovf_r, udf_r, peak_r);
        end
    endtask

    task automatic test_registered_read();
        logic [DATA_W-1:0] pat [3];
        pat[0] = 8'h11;
        pat[1] = 8'h22;
        pat[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data = pat[i];
            tick();
        end
        wr_valid = 1'b0;
        checks++;
        if (count_r !== 4'd3) begin
            failures++;
            $display("FAIL rr_count_after_write got=%0d exp=3", count_r);
        end
        checks++;
        if (rd_dvalid_r !== 1'b0) begin
            failures++;
            $display("FAIL rr_no_dvalid_before_read got=%b exp=0", rd_dvalid_r);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rd_dvalid_r !== 1'b1 || rd_data_r !== pat[i] || count_r !== 4'(2 - i)) begin
                failures++;
                $display("FAIL rr_read%0d got dv=%b data=%0h cnt=%0d exp dv=1 data=%0h cnt=%0d",
                         i, rd_dvalid_r, rd_data_r, count_r, pat[i], 2 - i);
            end
        end
        rd_en = 1'b0;
        tick();
        checks++;
        if (rd_dvalid_r !== 1'b0 || rd_data_r !== 8'h33 || empty_r !== 1'b1) begin
            failures++;
            $display("FAIL rr_hold got dv=%b data=%0h empty=%b exp dv=0 data=33 empty=1",
                     rd_dvalid_r, rd_data_r, empty_r);
        end
    endtask

    task automatic test_fill_ovf();
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1'b1;
            wr_data = 8'($urandom);
            tick();
        end
        checks++;
        if ({full_r, wr_ready_r} !== 2'b10 || count_r !== 4'd8 || ovf_r !== 1'b0) begin
            failures++;
            $display("FAIL fill_full got full=%b rdy=%b cnt=%0d ovf=%b exp full=1 rdy=0 cnt=8 ovf=0",
                     full_r, wr_ready_r, count_r, ovf_r);
        end
        wr_data = 8'hFE;
        tick();
        checks++;
        if (ovf_r !== 1'b1 || ovf_f !== 1'b1 || count_r !== 4'd8) begin
            failures++;
            $display("FAIL fill_ovf got ovf=%b/%b cnt=%0d exp ovf=1 cnt=8", ovf_r, ovf_f, count_r);
        end
        clr_err = 1'b1;
        tick();
        checks++;
        if (ovf_r !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set_wins got=%b exp=1", ovf_r);
        end
        wr_valid = 1'b0;
        tick();
        clr_err = 1'b0;
        checks++;
        if (ovf_r !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got=%b exp=0", ovf_r);
        end
    endtask

    task automatic test_full_simul();
        logic [DATA_W-1:0] exp_d;
        exp_d = q[0];
        wr_valid = 1'b1;
        rd_en = 1'b1;
        wr_data = 8'hEE;
        tick();
        checks++;
        if (count_r !== 4'd7 || rd_dvalid_r !== 1'b1 || rd_data_r !== exp_d) begin
            failures++;
            $display("FAIL full_simul got cnt=%0d dv=%b data=%0h exp cnt=7 dv=1 data=%0h",
                     count_r, rd_dvalid_r, rd_data_r, exp_d);
        end
        rd_en = 1'b0;
        wr_data = 8'($urandom);
        tick();
        wr_valid = 1'b0;
        checks++;
        if (count_r !== 4'd8 || full_r !== 1'b1) begin
            failures++;
            $display("FAIL full_refill got cnt=%0d full=%b exp cnt=8 full=1", count_r, full_r);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        test_random(20, 1'b0);
    endtask

    task automatic test_empty_udf();
        rd_en = 1'b1;
        for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) begin
            tick();
            checks++;
            if (rd_dvalid_r !== 1'b1 || rd_data_r !== m_rdata) begin
                failures++;
                $display("FAIL drain_order got dv=%b data=%0h exp dv=1 data=%0h", rd_dvalid_r, rd_data_r, m_rdata);
            end
        end
        rd_en = 1'b0;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if (empty_r !== 1'b1 || udf_r !== 1'b0) begin
            failures++;
            $display("FAIL drained got empty=%b udf=%b exp empty=1 udf=0", empty_r, udf_r);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (udf_r !== 1'b1 || udf_f !== 1'b1 || rd_dvalid_r !== 1'b0 || count_r !== 4'd0) begin
            failures++;
            $display("FAIL udf got udf=%b/%b dv=%b cnt=%0d exp udf=1 dv=0 cnt=0", udf_r, udf_f, rd_dvalid_r, count_r);
        end
        wr_valid = 1'b1;
        wr_data = 8'hA5;
        #1;
        checks++;
        if (rd_dvalid_f !== 1'b0) begin
            failures++;
            $display("FAIL fwft_no_bypass got dv=%b exp=0", rd_dvalid_f);
        end
        tick();
        wr_valid = 1'b0;
        checks++;
        if (rd_dvalid_f !== 1'b1 || rd_data_f !== 8'hA5) begin
            failures++;
            $display("FAIL fwft_show got dv=%b data=%0h exp dv=1 data=a5", rd_dvalid_f, rd_data_f);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (empty_f !== 1'b1 || rd_dvalid_f !== 1'b0) begin
            failures++;
            $display("FAIL fwft_pop got empty=%b dv=%b exp empty=1 dv=0", empty_f, rd_dvalid_f);
        end
        wr_valid = 1'b1;
        rd_en = 1'b1;
        wr_data = 8'h5A;
        tick();
        wr_valid = 1'b0;
        rd_en = 1'b0;
        checks++;
        if (count_r !== 4'd1 || rd_dvalid_r !== 1'b0 || udf_r !== 1'b1 || rd_data_f !== 8'h5A) begin
            failures++;
            $display("FAIL empty_simul got cnt=%0d dv=%b udf=%b fdata=%0h exp cnt=1 dv=0 udf=1 fdata=5a",
                     count_r, rd_dvalid_r, udf_r, rd_data_f);
        end
    endtask

    task automatic test_thresholds();
        do_reset();
        cfg_afull_th = 4'd6;
        cfg_aempty_th = 4'd1;
        for (int i = 0; i <= DEPTH; i++) begin
            #1;
            checks++;
            if (count_r !== 4'(i) || alm_empty_r !== (i <= 1) || alm_full_r !== (i >= 6)) begin
                failures++;
                $display("FAIL thresh_at%0d got cnt=%0d ae=%b af=%b exp ae=%b af=%b",
                         i, count_r, alm_empty_r, alm_full_r, i <= 1, i >= 6);
            end
            if (i < DEPTH) begin
                wr_valid = 1'b1;
                wr_data = 8'($urandom);
                tick();
                wr_valid = 1'b0;
            end
        end
        cfg_afull_th = 4'd9;
        #1;
        checks++;
        if (alm_full_r !== 1'b0 || alm_full_f !== 1'b0) begin
            failures++;
            $display("FAIL thresh_afull9 got=%b/%b exp=0", alm_full_r, alm_full_f);
        end
        cfg_aempty_th = 4'd8;
        #1;
        checks++;
        if (alm_empty_r !== 1'b1) begin
            failures++;
            $display("FAIL thresh_aempty_depth got=%b exp=1", alm_empty_r);
        end
        do_reset();
        cfg_afull_th = 4'd0;
        cfg_aempty_th = 4'd0;
        #1;
        checks++;
        if (alm_full_r !== 1'b1 || alm_empty_r !== 1'b1) begin
            failures++;
            $display("FAIL thresh_zero got af=%b ae=%b exp af=1 ae=1", alm_full_r, alm_empty_r);
        end
        cfg_afull_th = 4'd8;
        cfg_aempty_th = 4'd0;
    endtask

    task automatic test_peak();
        logic [CW-1:0] exp_hi, exp_clr;
`ifdef SYNC_FIFO_PEAK_EN
        exp_hi = 4'd5;
        exp_clr = 4'd2;
`else
        exp_hi = 4'd0;
        exp_clr = 4'd0;
`endif
        do_reset();
        wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'($urandom);
            tick();
        end
        wr_valid = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rd_en = 1'b0;
        checks++;
        if (peak_r !== exp_hi || peak_f !== exp_hi || count_r !== 4'd2) begin
            failures++;
            $display("FAIL peak_hi got peak=%0d/%0d cnt=%0d exp peak=%0d cnt=2", peak_r, peak_f, count_r, exp_hi);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if (peak_r !== exp_clr) begin
            failures++;
            $display("FAIL peak_clr got=%0d exp=%0d", peak_r, exp_clr);
        end
        wr_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wr_data = 8'($urandom);
            rd_en = i == 0;
            tick();
        end
        checks++;
        if (ovf_r !== 1'b1 || rd_dvalid_r !== 1'b0) begin
            failures++;
            $display("FAIL burst_pre_reset got ovf=%b dv=%b exp ovf=1 dv=0", ovf_r, rd_dvalid_r);
        end
        rd_en = 1'b1;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        wr_valid = 1'b0;
        rd_en = 1'b0;
        checks++;
        if (count_r !== 4'd0 || {ovf_r, udf_r, rd_dvalid_r, rd_dvalid_f} !== 4'd0 || empty_f !== 1'b1 || peak_r !== 4'd0) begin
            failures++;
            $display("FAIL mid_reset got cnt=%0d ovf=%b udf=%b dv=%b dvf=%b emptyf=%b peak=%0d exp cnt=0 all 0 emptyf=1",
                     count_r, ovf_r, udf_r, rd_dvalid_r, rd_dvalid_f, empty_f, peak_r);
        end
    endtask

    task automatic test_random(input int n, input logic rand_cfg);
        int s;
        for (int i = 0; i < n; i++) begin
            wr_valid = $urandom_range(0, 99) < (((i / 16) % 2) ? 80 : 30);
            rd_en = $urandom_range(0, 99) < (((i / 16) % 2) ? 30 : 75);
            wr_data = 8'($urandom);
            clr_err = $urandom_range(0, 11) == 0;
            if (rand_cfg) begin
                cfg_afull_th = 4'($urandom_range(0, 15));
                cfg_aempty_th = 4'($urandom_range(0, 15));
            end
            tick();
            s = q.size();
            checks++;
            if (count_r !== 4'(s) || count_f !== 4'(s)) begin
                failures++;
                $display("FAIL rnd_count cyc=%0d got=%0d/%0d exp=%0d", i, count_r, count_f, s);
            end
            checks++;
            if ({empty_r, full_r, wr_ready_r, alm_full_r, alm_empty_r} !==
                {s == 0, s == DEPTH, s < DEPTH, s >= int'(cfg_afull_th), s <= int'(cfg_aempty_th)}) begin
                failures++;
                $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i,
                         {empty_r, full_r, wr_ready_r, alm_full_r, alm_empty_r},
                         {s == 0, s == DEPTH, s < DEPTH, s >= int'(cfg_afull_th), s <= int'(cfg_aempty_th)});
            end
            checks++;
            if ({ovf_r, udf_r, ovf_f, udf_f} !== {m_ovf, m_udf, m_ovf, m_udf}) begin
                failures++;
                $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, {ovf_r, udf_r, ovf_f, udf_f}, {m_ovf, m_udf, m_ovf, m_udf});
            end
            checks++;
            if (rd_dvalid_r !== m_dv || rd_data_r !== m_rdata) begin
                failures++;
                $display("FAIL rnd_rdreg cyc=%0d got dv=%b data=%0h exp dv=%b data=%0h", i, rd_dvalid_r, rd_data_r, m_dv, m_rdata);
            end
            checks++;
            if (rd_dvalid_f !== (s > 0) || (s > 0 && rd_data_f !== q[0])) begin
                failures++;
                $display("FAIL rnd_fwft cyc=%0d got dv=%b data=%0h exp dv=%b data=%0h", i, rd_dvalid_f, rd_data_f, s > 0, s > 0 ? q[0] : 8'h0);
            end
            checks++;
            if (peak_r !== 4'(m_peak) || peak_f !== 4'(m_peak)) begin
                failures++;
                $display("FAIL rnd_peak cyc=%0d got=%0d/%0d exp=%0d", i, peak_r, peak_f, m_peak);
            end
        end
        wr_valid = 1'b0;
        rd_en = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        wr_valid = 1'b0;
        wr_data = '0;
        rd_en = 1'b0;
        clr_err = 1'b0;
        cfg_afull_th = 4'd8;
        cfg_aempty_th = 4'd0;
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_dv = 1'b0;
        m_rdata = '0;
        m_peak = 0;
        #1;
        test_reset();
        test_registered_read();
        test_fill_ovf();
        test_full_simul();
        test_empty_udf();
        test_thresholds();
        test_peak();
        test_random(400, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_fifo_v2.md
Name: sync_fifo_v2

Overview:
Parametrised synchronous single-clock FIFO. It succeeds the fixed-threshold FIFO and adds the following:
- valid/ready write handshake
- selectable first-word-fall-through (FWFT) or registered-read mode
- run-time programmable almost-full/almost-empty thresholds
- occupancy output
- sticky overflow/underflow flags

It sits between producer and consumer datapath stages inside one clock domain.

Parameters:
DATA_W, 32, data width in bits (>=1)
DEPTH, 16, number of entries (>=2, need not be a power of two)
FWFT, 0, read mode: 0 = registered read with rd_dvalid pulse, 1 = first-word-fall-through
CW, $clog2(DEPTH)+1, derived width of the count and threshold fields (localparam, not overridable)

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  reset, synchronous, active-low
wr_valid  in  1  producer has data
wr_data  in  DATA_W  write data
wr_ready  out  1  FIFO can accept a write (= count < DEPTH)
rd_en  in  1  read/pop request
rd_data  out  DATA_W  read data
rd_dvalid  out  1  rd_data valid (meaning depends on FWFT)
empty  out  1  count == 0
full  out  1  count == DEPTH
count  out  CW  entries currently stored
cfg_afull_th  in  CW  almost-full threshold
cfg_aempty_th  in  CW  almost-empty threshold
alm_full  out  1  count >= cfg_afull_th
alm_empty  out  1  count <= cfg_aempty_th
clr_err  in  1  clears ovf, udf (and peak, see optional feature)
ovf  out  1  sticky: write attempted while full
udf  out  1  sticky: read attempted while empty
peak  out  CW  high-water mark (optional feature)

Behaviour:
- Reset (rstn=0 at posedge) drives every output and register to a defined value:
  - write pointer, read pointer, count, ovf, udf, peak = 0
  - rd_data = 0, rd_dvalid = 0
  - derived flags then read empty=1, full=0, wr_ready=1
  - storage array is not cleared
  - reset mid-operation discards all contents and in-flight reads.
- Write acceptance: wr_acc = wr_valid & wr_ready.
  - An accepted write stores wr_data at the write pointer and advances the pointer.
  - The pointer wraps from DEPTH-1 to 0.
- Read acceptance: rd_acc = rd_en & !empty.
  - An accepted read advances the read pointer, with the same wrap rule.
- Count update:
  - +1 on write only
  - -1 on read only
  - unchanged when both or neither are accepted
  - count never exceeds DEPTH and never underflows.
- Full with wr_valid & rd_en together: write rejected (wr_ready=0), read accepted; count becomes DEPTH-1.
- Empty with wr_valid & rd_en together: read rejected, write accepted; count becomes 1.
  - No bypass: data is never read in the same cycle it is written.
- FWFT=0 (registered read):
  - On rd_acc, rd_data <= mem[rdptr]; rd_dvalid = 1 for exactly the following cycle, otherwise 0.
  - rd_data holds its last value between reads.
  - Read latency is 1 cycle.
- FWFT=1 (first-word-fall-through):
  - rd_data = mem[rdptr] combinationally; rd_dvalid = !empty.
  - rd_en acts as pop/acknowledge of the presented word.
  - The first write into an empty FIFO is visible on rd_data the cycle after acceptance.
- Error flags:
  - ovf sets the cycle after wr_valid & !wr_ready.
  - udf sets the cycle after rd_en & empty.
  - Both hold until clr_err.
  - If clr_err and a new error event occur in the same cycle, set wins.
- Thresholds:
  - Compared combinationally against registered count; may change any cycle, effect is immediate.
  - cfg_afull_th=0 forces alm_full=1.
  - cfg_aempty_th >= DEPTH forces alm_empty=1.
- Width rule: count, thresholds and peak are unsigned CW-bit values; comparisons are unsigned.

Optional Feature:
- Macro: SYNC_FIFO_PEAK_EN.
- When defined:
  - peak register records max(count) seen since reset or the last clr_err.
  - Updates the cycle after count rises above peak.
  - clr_err loads peak with the current count.
- When not defined: peak is tied to 0 and no register is built. The port always exists.

Test Plan:
All scenarios use DEPTH=8, DATA_W=8.
1. FWFT=0: write 0x11, 0x22, 0x33, then rd_en 3 cycles -> rd_dvalid pulses the cycle after each read with 0x11, 0x22, 0x33; count 3->0; empty=1.
2. Fill: write 8 words -> full=1, wr_ready=0, count=8; 9th write with wr_valid=1 -> data dropped, ovf=1 next cycle; clr_err -> ovf=0.
3. Full with simultaneous write and read -> read accepted, write rejected, count=7; next cycle write accepted -> count=8. Then 20 mixed ops with pointer wrap -> scoreboard order intact.
4. Empty: rd_en -> udf=1, rd_dvalid stays 0. FWFT=1: write 0xA5 -> next cycle rd_dvalid=1, rd_data=0xA5; rd_en -> empty=1 next cycle.
5. cfg_afull_th=6, cfg_aempty_th=1: fill 0->8 -> alm_empty=1 at count 0..1; alm_full=1 from count 6. Change cfg_afull_th to 9 at count 8 -> alm_full=0 same cycle.
6. SYNC_FIFO_PEAK_EN: fill to 5, drain to 2 -> peak=5; clr_err -> peak=2. Reset asserted mid-burst -> count=0, ovf=udf=0, rd_dvalid=0 next cycle.
